// File: rtl/frame_pkg.sv
// Shared constants, FSM encoding and pixel helpers for the RGBA frame writer.
// Pure declarations: no logic, no latency, no flow control.
package frame_pkg;

  localparam int FB_WIDTH  = 300;
  localparam int FB_HEIGHT = 300;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 16;

  // Counter widths leave headroom so origin + size never wraps.
  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int ALPHA_LSB = 0;
  localparam int ALPHA_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [X_W-1:0] xe;
    logic [Y_W-1:0] ye;
  } span_t;

  function automatic logic pix_opaque(input logic [PIX_W-1:0] p);
    return p[ALPHA_LSB +: ALPHA_W] != '0;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Row-major cx/cy walker over the latched rectangle with a registered linear address.
// Address is valid one cycle after i_adv; no flow control of its own, advances only on i_adv.
module frame_addr_gen
  import frame_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [9:0]           i_x0,
  input  logic [8:0]           i_y0,
  input  logic [9:0]           i_w,
  input  logic [8:0]           i_h,
  input  logic                 i_adv,
  output logic                 o_last,
  output logic                 o_clip,
  output logic [FB_ADDR_W-1:0] o_addr
);

  span_t                r_span;
  logic [X_W-1:0]       r_cx;
  logic [Y_W-1:0]       r_cy;
  logic [FB_ADDR_W-1:0] r_addr;
  logic                 w_eol;
  logic [FB_ADDR_W-1:0] w_lin;

  assign w_eol  = (r_cx == r_span.xe);
  assign o_last = w_eol && (r_cy == r_span.ye);
  assign o_clip = (r_cx >= X_W'(WIDTH)) || (r_cy >= Y_W'(HEIGHT));
  assign o_addr = r_addr;

  // Worst case 1023*300 + 2047 still fits in 19 bits, so this width is exact.
  assign w_lin = FB_ADDR_W'(r_cy) * FB_ADDR_W'(WIDTH) + FB_ADDR_W'(r_cx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_span <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_span.x0 <= {1'b0, i_x0};
      r_span.xe <= {1'b0, i_x0} + {1'b0, i_w} - 11'd1;
      r_span.ye <= {1'b0, i_y0} + {1'b0, i_h} - 10'd1;
      r_cx      <= {1'b0, i_x0};
      r_cy      <= {1'b0, i_y0};
    end else if (i_adv) begin
      r_addr <= w_lin;
      if (w_eol) begin
        r_cx <= r_span.x0;
        r_cy <= r_cy + 10'd1;
      end else begin
        r_cx <= r_cx + 11'd1;
      end
    end
  end

endmodule

// File: rtl/frame_writer_rgba.sv
// Writes a rectangle of RGBA pixels (solid fill or from a stream) into a BRAM port.
// One-cycle accept-to-write latency; s_ready is low outside stream-mode RUN, fill never stalls.
module frame_writer_rgba
  import frame_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9:0]           x0,
  input  logic [8:0]           y0,
  input  logic [9:0]           w,
  input  logic [8:0]           h,
  input  logic                 fill,
  input  logic [PIX_W-1:0]     fill_color,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PIX_W-1:0]     s_pixel,
  output logic                 mem_we,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]     mem_din,
  output logic                 busy,
  output logic                 done
);

  state_t             r_state;
  state_t             w_next;
  logic               r_fill;
  logic [PIX_W-1:0]   r_color;
  logic               r_we;
  logic [PIX_W-1:0]   r_din;
  logic               r_zero_done;
  logic               w_load;
  logic               w_accept;
  logic               w_last;
  logic               w_clip;
  logic               w_zero;
  logic [PIX_W-1:0]   w_pix;

  assign w_zero = (w == '0) || (h == '0);
  assign w_pix  = r_fill ? r_color : s_pixel;

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_accept = 1'b0;
    busy     = 1'b0;
    s_ready  = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        done = r_zero_done;
        if (start && !w_zero) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        s_ready  = !r_fill;
        w_accept = r_fill || s_valid;
        if (w_accept && w_last) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fill      <= 1'b0;
      r_color     <= '0;
      r_we        <= 1'b0;
      r_din       <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Zero-area commands never leave IDLE; they only echo a done pulse.
      r_zero_done <= (r_state == ST_IDLE) && start && w_zero;
      if (w_load) begin
        r_fill  <= fill;
        r_color <= fill_color;
      end
      r_we <= w_accept && !w_clip && pix_opaque(w_pix);
      if (w_accept) r_din <= w_pix;
    end
  end

  frame_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_x0   (x0),
    .i_y0   (y0),
    .i_w    (w),
    .i_h    (h),
    .i_adv  (w_accept),
    .o_last (w_last),
    .o_clip (w_clip),
    .o_addr (mem_addr)
  );

  assign mem_we  = r_we;
  assign mem_din = r_din;

endmodule

// File: doc/frame_writer_rgba.md
FRAME_WRITER_RGBA -- requirements
Module: frame_writer_rgba

Interface
REQ-001 SHALL have parameter WIDTH, default 300, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 300, frame height in pixels.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle command strobe.
REQ-006 SHALL have ports x0 input 10, y0 input 9, w input 10 and h input 9: rectangle origin and size, sampled on an accepted start.
REQ-007 SHALL have port fill  input  1  sampled on start; 1 = write fill_color, 0 = consume the stream.
REQ-008 SHALL have port fill_color  input  16  RGBA R[15:12] G[11:8] B[7:4] A[3:0], sampled on start.
REQ-009 SHALL have ports s_valid input 1, s_ready output 1 and s_pixel input 16: pixel stream, RGBA, row-major.
REQ-010 SHALL have ports mem_we output 1, mem_addr output 19 and mem_din output 16: BRAM write port, all registered.
REQ-011 SHALL have port busy  output  1  high while a command is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a command completes.

Function
REQ-013 SHALL implement states IDLE, RUN and FLUSH.
- IDLE->RUN on start, with w!=0 and h!=0.
- RUN->FLUSH after the last pixel (w*h-th) is accepted.
- FLUSH->IDLE after one cycle, asserting done in that cycle.
REQ-014 SHALL treat start with w==0 or h==0 as a zero-area command: no writes, done pulses exactly one cycle later, busy stays low.
REQ-015 SHALL ignore start while busy is high; the latched command is unaffected.
REQ-016 SHALL assert busy in RUN and FLUSH only.
REQ-017 SHALL drive s_ready = 1 only in RUN with fill==0; s_ready is 0 in IDLE, FLUSH and fill mode.
REQ-018 SHALL define a pixel as accepted when s_valid & s_ready (stream mode), or on every RUN cycle (fill mode, one pixel per cycle).
REQ-019 SHALL traverse pixels row-major with internal counters cx (x0..x0+w-1) and cy (y0..y0+h-1); at cx = x0+w-1, cx wraps to x0 and cy increments.
REQ-020 SHALL register mem_addr = cy*WIDTH + cx at 19 bits, the product computed at full width with no truncation before the add.
REQ-021 SHALL have one-cycle latency: a pixel accepted in cycle N appears on mem_we/mem_addr/mem_din in cycle N+1.
REQ-022 SHALL deassert mem_we for an accepted pixel whose cx>=WIDTH or cy>=HEIGHT (clipped); the pixel is still consumed and the counters still advance.
REQ-023 SHALL deassert mem_we for an accepted pixel whose A nibble is 0 (transparent); the pixel is still consumed and the counters still advance.
REQ-024 SHALL hold mem_we = 0 whenever no pixel was accepted in the previous cycle; mem_addr and mem_din are don't-care then.
REQ-025 SHALL perform the last write in the FLUSH cycle, which is also the done cycle.
REQ-026 SHALL compute the counters and comparisons at x 11 bits and y 10 bits, so that x0+w and y0+h never overflow.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE and set busy=0, done=0, s_ready=0, mem_we=0, mem_addr=0, mem_din=0 and counters=0.
REQ-028 SHALL abandon an in-progress command when rst is asserted mid-command: no further writes and no done pulse.
REQ-029 SHALL give rst priority over a simultaneous start.

Structure
REQ-030 SHALL place the following in a shared package frame_pkg: FB_WIDTH=300, FB_HEIGHT=300, FB_ADDR_W=19, PIX_W=16, the state encoding and the alpha-nibble position.
REQ-031 SHALL contain one sub-module, frame_addr_gen, holding the cx/cy counters, wrap logic, last-pixel flag and registered address.

Verification
REQ-032 SHALL verify stream mode: start x0=2 y0=3 w=3 h=2, six stream pixels 0x1111..0x6666 (A!=0), s_valid held high -> writes at addresses 902,903,904,1202,1203,1204 in order; done 1 cycle after the last write is accepted; busy low afterwards.
REQ-033 SHALL verify fill mode and clipping: fill=1, color 0xF00F, x0=298 y0=0 w=4 h=1 -> exactly 2 writes (addresses 298 and 299), 4 RUN cycles, done once.
REQ-034 SHALL verify transparency and backpressure: stream mode w=4 h=1, s_valid toggling 1,0,1,0..., pixels 0xABC0, 0x1231, 0x0000, 0xFFFF -> writes only for the 2nd and 4th pixels; no write in any cycle following s_valid=0.
REQ-035 SHALL verify zero area and start-while-busy: start w=0 -> done after 1 cycle with no mem_we; a second start during a 10-pixel fill -> ignored, exactly 10 writes.
REQ-036 SHALL verify reset mid-operation: assert rst after 5 of 9 fill pixels -> next cycle mem_we=0 and busy=0, no done, and a subsequent start works normally.
REQ-037 SHALL verify the address corner: pixel (299,299) -> mem_addr = 89999.
